button_arbiter: RTL and testbench

BUTTON_ARBITER -- requirements
Module: button_arbiter

---
 rtl/button_arbiter.sv | 179 +++++++++++++++++
 tb/tb_button_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/button_arbiter.sv
// Button press arbiter: gathers one-cycle press pulses from four colour buttons
// during a player-input window, serialises simultaneous presses in round-robin
// order into a small event FIFO, and times out an idle window.
module button_arbiter #(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       arm,
    input  logic       disarm,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [1:0] ev_color,
    output logic       armed,
    output logic       timeout,
    output logic       overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_ARMED
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [TW-1:0]  r_timer;
    logic [TW-1:0]  w_timer_next;
    logic           w_timeout;
    logic           w_ovf_clear;
    logic           w_collision;
    logic           r_overflow;

    logic [3:0]     r_pending;
    logic [3:0]     w_pending_next;
    logic [3:0]     w_req;
    logic [1:0]     r_last_grant;
    logic [1:0]     w_grant_idx;
    logic [1:0]     w_cand;
    logic           w_grant;

    logic [1:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_full;
    logic           w_push;
    logic           w_pop;
    logic           w_valid;

    // Window FSM: next state, timer and timeout pulse. A press in the
    // would-be timeout cycle wins over the timeout.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_timeout    = 1'b0;
        w_ovf_clear  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timer_next = '0;
                if (arm) begin
                    w_state_next = S_ARMED;
                    w_ovf_clear  = 1'b1;
                end
            end
            S_ARMED: begin
                if (disarm) begin
                    w_state_next = S_IDLE;
                    w_timer_next = '0;
                end else if (arm) begin
                    w_timer_next = '0;
                    w_ovf_clear  = 1'b1;
                end else if (btn != 4'b0000) begin
                    w_timer_next = '0;
                end else if (r_timer == TMAX) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_timer_next = '0;
            end
        endcase
    end

    // FSM state and window timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
        end
    end

    // Round-robin search upward from the slot after the last grant; a full
    // FIFO blocks granting so every request stays pending.
    always_comb begin
        w_req       = r_pending | ((r_state == S_ARMED) ? btn : 4'b0000);
        w_grant     = 1'b0;
        w_grant_idx = r_last_grant;
        w_cand      = r_last_grant;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last_grant + 2'(k);
            if (!w_grant && !w_full && w_req[w_cand]) begin
                w_grant     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
        w_pending_next = w_grant ? (w_req & ~(4'b0001 << w_grant_idx)) : w_req;
        w_collision    = (r_state == S_ARMED) && ((btn & r_pending) != 4'b0000);
    end

    // Pending requests, last grant and the sticky lost-press flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending    <= 4'b0000;
            r_last_grant <= 2'd3;
            r_overflow   <= 1'b0;
        end else begin
            r_pending  <= w_pending_next;
            r_overflow <= (w_ovf_clear ? 1'b0 : r_overflow) | w_collision;
            if (w_grant) begin
                r_last_grant <= w_grant_idx;
            end
        end
    end

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = w_valid & ev_ready;
    assign w_push  = w_grant;

    // Event storage; contents need no reset because the count gates validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_grant_idx;
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide when not full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign ev_valid = w_valid;
    assign ev_color = w_valid ? r_mem[r_rd_ptr] : 2'b00;
    assign armed    = (r_state == S_ARMED);
    assign timeout  = w_timeout;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_button_arbiter.sv
// Directed bench for button_arbiter with an 8-cycle window and 4-deep FIFO.
module tb_button_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic       arm;
    logic       disarm;
    logic       ev_ready;
    logic       ev_valid;
    logic [1:0] ev_color;
    logic       armed;
    logic       timeout;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    button_arbiter #(
        .TIMEOUT_CYCLES(8),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .arm     (arm),
        .disarm  (disarm),
        .ev_ready(ev_ready),
        .ev_valid(ev_valid),
        .ev_color(ev_color),
        .armed   (armed),
        .timeout (timeout),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        btn    = 4'b0000;
        arm    = 1'b0;
        disarm = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; btn = 4'b0000; arm = 1'b0; disarm = 1'b0; ev_ready = 1'b0;
        tick(); tick();
        chk("rst_ev_valid", 32'(ev_valid), 32'd0);
        chk("rst_ev_color", 32'(ev_color), 32'd0);
        chk("rst_armed",    32'(armed),    32'd0);
        chk("rst_timeout",  32'(timeout),  32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();

        // Single press, one-cycle latency, immediate pop.
        arm = 1'b1; tick(); clr();
        chk("arm_armed", 32'(armed), 32'd1);
        ev_ready = 1'b1; btn = 4'b0100; tick(); clr();
        chk("lone_valid", 32'(ev_valid), 32'd1);
        chk("lone_color", 32'(ev_color), 32'd2);
        tick();
        chk("lone_popped", 32'(ev_valid), 32'd0);

        // All four at once from last_grant=3: order 0,1,2,3.
        rst = 1'b1; tick(); rst = 1'b0;
        arm = 1'b1; tick(); clr();
        ev_ready = 1'b0; btn = 4'b1111; tick(); clr();
        chk("rr4_head0", 32'(ev_color), 32'd0);
        tick(); tick(); tick();
        chk("rr4_pending_drained", 32'(dut.r_pending), 32'd0);
        chk("rr4_head_stable", 32'(ev_color), 32'd0);
        ev_ready = 1'b1; arm = 1'b1; tick(); clr();
        chk("rr4_head1", 32'(ev_color), 32'd1);
        tick();
        chk("rr4_head2", 32'(ev_color), 32'd2);
        tick();
        chk("rr4_head3", 32'(ev_color), 32'd3);
        tick();
        chk("rr4_empty", 32'(ev_valid), 32'd0);

        // Set last_grant=1, then 1001 must come out as 3 then 0.
        arm = 1'b1; btn = 4'b0010; tick(); clr();
        chk("lg1_color", 32'(ev_color), 32'd1);
        tick();
        ev_ready = 1'b0; arm = 1'b1; btn = 4'b1001; tick(); clr();
        chk("rr2_head3", 32'(ev_color), 32'd3);
        tick();
        chk("rr2_head3_stable", 32'(ev_color), 32'd3);
        ev_ready = 1'b1; tick();
        chk("rr2_head0", 32'(ev_color), 32'd0);
        tick();
        chk("rr2_empty", 32'(ev_valid), 32'd0);
        ev_ready = 1'b0;

        // Full FIFO, repeated press of colour 1 -> overflow and pending.
        rst = 1'b1; tick(); rst = 1'b0;
        arm = 1'b1; tick(); clr();
        btn = 4'b1111; tick(); clr();
        tick(); tick(); tick();
        btn = 4'b0010; tick(); clr();
        chk("full_pending", 32'(dut.r_pending), 32'h2);
        chk("full_no_ovf", 32'(overflow), 32'd0);
        btn = 4'b0010; tick(); clr();
        chk("full_overflow", 32'(overflow), 32'd1);
        chk("full_pending2", 32'(dut.r_pending), 32'h2);
        chk("full_head", 32'(ev_color), 32'd0);
        ev_ready = 1'b1; tick(); ev_ready = 1'b0;
        chk("pop_full_no_push", 32'(dut.r_pending), 32'h2);
        tick();
        chk("push_after_pop", 32'(dut.r_pending), 32'h0);
        ev_ready = 1'b1;
        chk("ovf_head1", 32'(ev_color), 32'd1);
        tick();
        chk("ovf_head2", 32'(ev_color), 32'd2);
        tick();
        chk("ovf_head3", 32'(ev_color), 32'd3);
        tick();
        chk("ovf_head_merged1", 32'(ev_color), 32'd1);
        tick();
        chk("ovf_empty", 32'(ev_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        arm = 1'b1; tick(); clr();
        chk("ovf_cleared_by_arm", 32'(overflow), 32'd0);

        // Timeout 8 cycles after arm.
        disarm = 1'b1; tick(); clr();
        chk("disarm_idle", 32'(armed), 32'd0);
        arm = 1'b1; tick(); clr();
        for (int i = 0; i < 6; i++) tick();
        chk("to_not_yet", 32'(timeout), 32'd0);
        tick();
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_still_armed", 32'(armed), 32'd1);
        tick();
        chk("to_disarmed", 32'(armed), 32'd0);
        chk("to_one_cycle", 32'(timeout), 32'd0);

        // Press in the would-be timeout cycle beats the timeout.
        arm = 1'b1; tick(); clr();
        for (int i = 0; i < 7; i++) tick();
        ev_ready = 1'b1; btn = 4'b0001; #1;
        chk("press_wins_no_to", 32'(timeout), 32'd0);
        tick(); clr();
        chk("press_wins_armed", 32'(armed), 32'd1);
        chk("press_wins_event", 32'(ev_color), 32'd0);
        tick();
        chk("press_wins_drained", 32'(ev_valid), 32'd0);

        // Presses in IDLE are ignored; arm+disarm together disarms.
        disarm = 1'b1; tick(); clr();
        btn = 4'b1111; tick(); btn = 4'b0101; tick(); clr(); tick();
        chk("idle_no_events", 32'(ev_valid), 32'd0);
        chk("idle_no_ovf", 32'(overflow), 32'd0);
        arm = 1'b1; tick(); clr();
        chk("rearm", 32'(armed), 32'd1);
        arm = 1'b1; disarm = 1'b1; tick(); clr();
        chk("disarm_wins", 32'(armed), 32'd0);

        // Asynchronous reset with three events queued.
        arm = 1'b1; tick(); clr();
        ev_ready = 1'b0; btn = 4'b0111; tick(); clr(); tick(); tick();
        chk("q3_valid_before", 32'(ev_valid), 32'd1);
        chk("q3_count", 32'(dut.r_count), 32'd3);
        #2 rst = 1'b1; #1;
        chk("async_ev_valid", 32'(ev_valid), 32'd0);
        chk("async_armed",    32'(armed),    32'd0);
        chk("async_overflow", 32'(overflow), 32'd0);
        chk("async_color",    32'(ev_color), 32'd0);
        tick(); rst = 1'b0;
        ev_ready = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_no_events", 32'(ev_valid), 32'd0);
        chk("post_rst_idle", 32'(armed), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
